uart_rx_deframer: RTL and testbench

- Serial receive front end of the UART.
- Samples the asynchronous Rx line, recovers the frame (start, data, parity, stop bits), checks it, and presents one parallel word per frame, with error flags, to the receive FIFO write port.
- Also drives RTS flow control from the FIFO full status.
- Sits between the Rx pin and the receive FIFO; its Data_Out, Data_Rdy and Rx_Error outputs feed the FIFO.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_rx_deframer.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - Rx_Error bit positions
//   - receive FSM state encoding
//   - helpers for bit period length and timer width
package uart_pkg;

    localparam int ERR_BREAK  = 0;
    localparam int ERR_PARITY = 1;
    localparam int ERR_FRAME  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    function automatic int clks_per_bit(input int sysclk_rate, input int baud_rate);
        return sysclk_rate / baud_rate;
    endfunction

    // Timer counts down from clks_per_bit-1 to 0.
    function automatic int cnt_width(input int cpb);
        return (cpb <= 2) ? 1 : $clog2(cpb);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the Rx pin plus falling-edge detect.
// Ports:
//   Clk      receive clock
//   Rst      asynchronous active-low reset (flops reset to idle level 1)
//   Rx       raw serial line
//   rx_s     synchronized line
//   rx_s_d   rx_s delayed by one cycle
//   rx_fall  rx_s went 1 -> 0 this cycle
module uart_rx_sync (
    input  logic Clk,
    input  logic Rst,
    input  logic Rx,
    output logic rx_s,
    output logic rx_s_d,
    output logic rx_fall
);

    logic rx_meta;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign rx_fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: recovers start/data/parity/stop bits from the
// synchronized Rx line, checks the frame and strobes one word per frame
// into the receive FIFO. Also drives RTS from FIFO_Full.
// Ports:
//   Clk, Rst (async active-low)
//   Rx         serial input, idle high
//   FIFO_Full  receive FIFO full
//   RTS        registered !FIFO_Full
//   Data_Out   last received word (MSB received first)
//   Data_Rdy   one-cycle FIFO write strobe
//   Rx_Error   [0] break, [1] parity, [2] frame
//   Rx_Busy    frame in progress
// Build option: UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote around the
// bit midpoint instead of a single midpoint sample.
//
// state      | meaning
// IDLE       | waiting for falling edge on rx_s
// START      | timing to start-bit midpoint, reject false starts
// DATA       | sampling DATA_BITS data bits
// PARITY     | sampling the even-parity bit
// STOP       | sampling stop bits, emitting the word on the last one
// BREAK_WAIT | line held low; wait for a full bit time of high
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int STOP_BITS   = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic                 FIFO_Full,
    output logic                 RTS,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic                 Data_Rdy,
    output logic [2:0]           Rx_Error,
    output logic                 Rx_Busy
);

    localparam int CPB = clks_per_bit(SYSCLK_RATE, BAUD_RATE);
    localparam int TW  = cnt_width(CPB);

    // Decisions are made one cycle after the midpoint so that both the
    // single-sample and voted builds share identical timing.
    localparam logic [TW-1:0] T_BIT  = TW'(CPB - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CPB / 2 - 1);

    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx_deframer: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_BITS < 1 || DATA_BITS > 8) begin : g_data_check
        $error("uart_rx_deframer: DATA_BITS must be 1..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_rx_deframer: STOP_BITS must be 1..2");
    end

    logic rx_s, rx_s_d, rx_fall;

    uart_rx_sync u_sync (
        .Clk     (Clk),
        .Rst     (Rst),
        .Rx      (Rx),
        .rx_s    (rx_s),
        .rx_s_d  (rx_s_d),
        .rx_fall (rx_fall)
    );

    logic bit_v;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic rx_s_d2;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) rx_s_d2 <= 1'b1;
        else      rx_s_d2 <= rx_s_d;
    end

    // rx_s_d2 / rx_s_d / rx_s = midpoint-1 / midpoint / midpoint+1
    assign bit_v = (rx_s_d2 & rx_s_d) | (rx_s_d2 & rx_s) | (rx_s_d & rx_s);
`else
    assign bit_v = rx_s_d;
`endif

    rx_state_t            state;
    logic [TW-1:0]        timer;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 stop_any_zero;
    logic                 stop_all_zero;

    logic       stop_any_next, stop_all_next, is_break;
    logic [2:0] err_next;

    always_comb begin
        stop_any_next = stop_any_zero | ~bit_v;
        stop_all_next = stop_all_zero & ~bit_v;
        is_break      = (shreg == '0) && (par_bit == 1'b0) && stop_all_next;
        err_next      = 3'b000;
        if (is_break) begin
            err_next[ERR_BREAK] = 1'b1;
        end else begin
            err_next[ERR_FRAME]  = stop_any_next;
            err_next[ERR_PARITY] = (PARITY_BIT != 0) && (par_bit != ^shreg);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= IDLE;
            timer         <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            stop_any_zero <= 1'b0;
            stop_all_zero <= 1'b1;
            RTS           <= 1'b0;
            Data_Out      <= '0;
            Data_Rdy      <= 1'b0;
            Rx_Error      <= 3'b000;
            Rx_Busy       <= 1'b0;
        end else begin
            RTS      <= !FIFO_Full;
            Data_Rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_fall) begin
                        state   <= START;
                        timer   <= T_HALF;
                        bit_cnt <= '0;
                        Rx_Busy <= 1'b1;
                    end
                end
                START: begin
                    if (timer == '0) begin
                        if (bit_v) begin
                            state   <= IDLE;
                            Rx_Busy <= 1'b0;
                        end else begin
                            state <= DATA;
                            timer <= T_BIT;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        timer <= T_BIT;
                        shreg <= DATA_BITS'({shreg, bit_v});
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            bit_cnt       <= '0;
                            stop_any_zero <= 1'b0;
                            stop_all_zero <= 1'b1;
                            state         <= (PARITY_BIT != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                PARITY: begin
                    if (timer == '0) begin
                        timer   <= T_BIT;
                        par_bit <= bit_v;
                        state   <= STOP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                STOP: begin
                    if (timer == '0) begin
                        timer         <= T_BIT;
                        stop_any_zero <= stop_any_next;
                        stop_all_zero <= stop_all_next;
                        if (bit_cnt == 3'(STOP_BITS - 1)) begin
                            Data_Rdy <= 1'b1;
                            Data_Out <= shreg;
                            Rx_Error <= err_next;
                            if (is_break) begin
                                state <= BREAK_WAIT;
                            end else begin
                                state   <= IDLE;
                                Rx_Busy <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                BREAK_WAIT: begin
                    // Any low sample restarts the full bit time of high.
                    if (!rx_s) begin
                        timer <= T_BIT;
                    end else if (timer == '0) begin
                        state   <= IDLE;
                        Rx_Busy <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    Rx_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer at 16 clocks per bit.
module tb_uart_rx_deframer;

    localparam int CPB = 16;
    // Rx driven low just after edge k: start seen at k+3, each decision
    // at midpoint+1, last of 12 bits decided at k+11+11*16.
    localparam int RDY_LAT = 11 + 11 * CPB;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx = 1'b1;
    logic       FIFO_Full = 1'b0;
    logic       RTS;
    logic [7:0] Data_Out;
    logic       Data_Rdy;
    logic [2:0] Rx_Error;
    logic       Rx_Busy;

    uart_rx_deframer #(
        .SYSCLK_RATE (153600),
        .BAUD_RATE   (9600)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Rx        (Rx),
        .FIFO_Full (FIFO_Full),
        .RTS       (RTS),
        .Data_Out  (Data_Out),
        .Data_Rdy  (Data_Rdy),
        .Rx_Error  (Rx_Error),
        .Rx_Busy   (Rx_Busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int         rdy_cnt = 0;
    int         dbl_cnt = 0;
    int         rdy_cyc = 0;
    logic [7:0] cap_data = 8'h00;
    logic [2:0] cap_err = 3'b000;
    logic       prev_rdy = 1'b0;

    always @(negedge Clk) begin
        if (Data_Rdy === 1'b1) begin
            rdy_cnt  = rdy_cnt + 1;
            rdy_cyc  = cyc;
            cap_data = Data_Out;
            cap_err  = Rx_Error;
            if (prev_rdy) dbl_cnt = dbl_cnt + 1;
        end
        prev_rdy = (Data_Rdy === 1'b1);
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (act === exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // start, data MSB first, parity, stop[1] then stop[0]
    task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] st);
        logic [11:0] bits;
        bits = {1'b0, d, p, st};
        for (int i = 11; i >= 0; i--) begin
            Rx = bits[i];
            tick(CPB);
        end
        Rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [1:0] stops;
        logic [2:0] exp_err;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int c0;
        int t0;

        vecs[0] = '{8'hA5, 1'b0, 2'b11, 3'b000};
        vecs[1] = '{8'hAA, 1'b1, 2'b11, 3'b010};
        vecs[2] = '{8'hAA, 1'b0, 2'b00, 3'b100};
        vecs[3] = '{8'h3C, 1'b0, 2'b11, 3'b000};
        vecs[4] = '{8'hAA, 1'b1, 2'b00, 3'b110};
        vecs[5] = '{8'h01, 1'b1, 2'b11, 3'b000};
        vecs[6] = '{8'h00, 1'b0, 2'b01, 3'b100};
        vecs[7] = '{8'hFF, 1'b0, 2'b10, 3'b100};
        vecs[8] = '{8'h00, 1'b1, 2'b00, 3'b110};

        // Reset state
        tick(3);
        check("rst_rts", {31'd0, RTS}, 0);
        check("rst_data", {24'd0, Data_Out}, 0);
        check("rst_rdy", {31'd0, Data_Rdy}, 0);
        check("rst_err", {29'd0, Rx_Error}, 0);
        check("rst_busy", {31'd0, Rx_Busy}, 0);
        Rst = 1'b1;
        check("rts_before_edge", {31'd0, RTS}, 0);
        tick(1);
        check("rts_after_release", {31'd0, RTS}, 1);
        tick(5);

        // Table-driven frames
        for (int i = 0; i < 9; i++) begin
            c0 = rdy_cnt;
            t0 = cyc;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stops);
            tick(20);
            check($sformatf("v%0d_count", i), rdy_cnt - c0, 1);
            check($sformatf("v%0d_data", i), {24'd0, cap_data}, {24'd0, vecs[i].data});
            check($sformatf("v%0d_err", i), {29'd0, cap_err}, {29'd0, vecs[i].exp_err});
            check($sformatf("v%0d_latency", i), rdy_cyc - t0, RDY_LAT);
            check($sformatf("v%0d_idle", i), {31'd0, Rx_Busy}, 0);
        end

        // Break: 12 bit times low
        c0 = rdy_cnt;
        Rx = 1'b0;
        tick(12 * CPB);
        Rx = 1'b1;
        check("brk_count", rdy_cnt - c0, 1);
        check("brk_err", {29'd0, cap_err}, 3'b001);
        check("brk_data", {24'd0, cap_data}, 0);
        tick(12);
        check("brk_busy_wait", {31'd0, Rx_Busy}, 1);
        tick(10);
        check("brk_busy_done", {31'd0, Rx_Busy}, 0);
        check("brk_no_extra", rdy_cnt - c0, 1);
        c0 = rdy_cnt;
        send_frame(8'h3C, 1'b0, 2'b11);
        tick(20);
        check("post_brk_count", rdy_cnt - c0, 1);
        check("post_brk_data", {24'd0, cap_data}, 8'h3C);
        check("post_brk_err", {29'd0, cap_err}, 0);

        // False start: 4-cycle low pulse
        c0 = rdy_cnt;
        Rx = 1'b0;
        tick(4);
        Rx = 1'b1;
        tick(1);
        check("fs_busy", {31'd0, Rx_Busy}, 1);
        tick(7);
        check("fs_busy_clear", {31'd0, Rx_Busy}, 0);
        tick(200);
        check("fs_no_rdy", rdy_cnt - c0, 0);

        // Reset during data bit 3 of an 8'h7F frame (all later bits high)
        c0 = rdy_cnt;
        fork
            send_frame(8'h7F, 1'b1, 2'b11);
            begin
                tick(4 * CPB + 8);
                Rst = 1'b0;
                #1;
                check("mid_rst_rts", {31'd0, RTS}, 0);
                check("mid_rst_data", {24'd0, Data_Out}, 0);
                check("mid_rst_rdy", {31'd0, Data_Rdy}, 0);
                check("mid_rst_err", {29'd0, Rx_Error}, 0);
                check("mid_rst_busy", {31'd0, Rx_Busy}, 0);
                tick(3);
                Rst = 1'b1;
            end
        join
        tick(30);
        check("mid_rst_no_rdy", rdy_cnt - c0, 0);
        check("mid_rst_idle", {31'd0, Rx_Busy}, 0);
        check("mid_rst_rts_back", {31'd0, RTS}, 1);

        // FIFO_Full drives RTS but does not block reception
        FIFO_Full = 1'b1;
        check("ff_rts_hold", {31'd0, RTS}, 1);
        tick(1);
        check("ff_rts_low", {31'd0, RTS}, 0);
        c0 = rdy_cnt;
        send_frame(8'hA5, 1'b0, 2'b11);
        tick(20);
        check("ff_count", rdy_cnt - c0, 1);
        check("ff_data", {24'd0, cap_data}, 8'hA5);
        check("ff_err", {29'd0, cap_err}, 0);
        check("ff_rts_still_low", {31'd0, RTS}, 0);
        FIFO_Full = 1'b0;
        tick(1);
        check("ff_rts_high", {31'd0, RTS}, 1);

        check("rdy_width", dbl_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
